// File: rtl/axis_stream_fifo.sv
// AXI4-Stream FIFO with first-word fall-through output,
// stored-beat count and stored-TLAST (packet) count.
module axis_stream_fifo #(
    parameter int DW    = 8,
    parameter int DEPTH = 16
) (
    input  logic                     ACLK,
    input  logic                     ARESETn,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic [DW-1:0]            s_axis_tdata,
    input  logic                     s_axis_tlast,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic [DW-1:0]            m_axis_tdata,
    output logic                     m_axis_tlast,
    output logic [$clog2(DEPTH):0]   count,
    output logic [$clog2(DEPTH):0]   pkt_count
);

    localparam int          AW  = $clog2(DEPTH);
    localparam logic [AW:0] ONE = (AW+1)'(1);

    logic [DW:0] mem_q [DEPTH];

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] cnt_q, cnt_d;
    logic [AW:0] pkt_q, pkt_d;
    logic        init_q;

    logic full, empty, wr, rd, pkt_inc, pkt_dec;

    // Pointers carry an extra wrap bit so full and empty are distinct.
    assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    assign s_axis_tready = init_q & ~full;
    assign m_axis_tvalid = ~empty;

    assign wr      = s_axis_tvalid & s_axis_tready;
    assign rd      = m_axis_tvalid & m_axis_tready;
    assign pkt_inc = wr & s_axis_tlast;
    assign pkt_dec = rd & m_axis_tlast;

    assign {m_axis_tlast, m_axis_tdata} = mem_q[rptr_q[AW-1:0]];

    assign count     = cnt_q;
    assign pkt_count = pkt_q;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        pkt_d  = pkt_q;
        if (wr) wptr_d = wptr_q + ONE;
        if (rd) rptr_d = rptr_q + ONE;
        unique case ({wr, rd})
            2'b10:   cnt_d = cnt_q + ONE;
            2'b01:   cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
        endcase
        unique case ({pkt_inc, pkt_dec})
            2'b10:   pkt_d = pkt_q + ONE;
            2'b01:   pkt_d = pkt_q - ONE;
            default: pkt_d = pkt_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            pkt_q  <= '0;
            init_q <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            pkt_q  <= pkt_d;
            init_q <= 1'b1;
        end
    end

    // Storage is not reset; the pointers alone define valid contents.
    always_ff @(posedge ACLK) begin
        if (wr) mem_q[wptr_q[AW-1:0]] <= {s_axis_tlast, s_axis_tdata};
    end

endmodule
